// File: rtl/playseq_jogador_automatico.sv
`default_nettype none
// ============================================================================
// Module      : playseq_jogador_automatico
// Description : Automatic PlaySeq player. Watches the game's LED preview,
//               captures the shown sequence, then replays it as timed one-hot
//               button presses until the game reports a win or a loss.
// Revision    : 1.0 - initial release
// ============================================================================
module playseq_jogador_automatico #(
    parameter int PROFUNDIDADE    = 16,
    parameter int PRESS_CICLOS    = 5,
    parameter int GAP_CICLOS      = 5,
    parameter int SILENCIO_CICLOS = 20
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          iniciar,
    input  logic [3:0]                    leds,
    input  logic                          ganhou,
    input  logic                          perdeu,
    output logic [3:0]                    botoes,
    output logic                          jogar,
    output logic                          fim,
    output logic                          erro,
    output logic [3:0]                    db_estado,
    output logic [$clog2(PROFUNDIDADE):0] db_contagem,
    output logic [$clog2(PROFUNDIDADE):0] db_indice
);

    // Buffer address width (kept at least 1 bit) and entry-count width
    // (one extra bit so a full buffer of PROFUNDIDADE entries is representable).
    localparam int c_aw    = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int c_cw    = $clog2(PROFUNDIDADE) + 1;
    // Single timer shared by silence, press and gap phases, sized for the
    // largest of the three durations.
    localparam int c_max_a = (PRESS_CICLOS > GAP_CICLOS) ? PRESS_CICLOS : GAP_CICLOS;
    localparam int c_max   = (c_max_a > SILENCIO_CICLOS) ? c_max_a : SILENCIO_CICLOS;
    localparam int c_tw    = $clog2(c_max + 1);

    localparam logic [c_tw-1:0] c_press    = c_tw'(PRESS_CICLOS);
    localparam logic [c_tw-1:0] c_gap      = c_tw'(GAP_CICLOS);
    localparam logic [c_tw-1:0] c_silencio = c_tw'(SILENCIO_CICLOS);
    localparam logic [c_cw-1:0] c_prof     = c_cw'(PROFUNDIDADE);

    typedef enum logic [3:0] {
        S_INICIAL    = 4'd0,
        S_DISPARA    = 4'd1,
        S_ESPERA_LED = 4'd2,
        S_LED_ALTO   = 4'd3,
        S_PRESSIONA  = 4'd4,
        S_INTERVALO  = 4'd5,
        S_FIM        = 4'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_cw-1:0]   r_n;
    logic [c_cw-1:0]   w_n_next;
    logic [c_cw-1:0]   r_idx;
    logic [c_cw-1:0]   w_idx_next;
    logic [c_tw-1:0]   r_timer;
    logic [c_tw-1:0]   w_timer_next;
    logic              r_erro;
    logic              w_erro_next;
    logic [3:0]        r_botoes;
    logic [3:0]        w_botoes_next;
    logic              w_wr;
    logic [3:0]        r_buf [PROFUNDIDADE];

    logic              w_abort;
    logic              w_leds_nz;
    logic              w_onehot;
    logic [c_tw-1:0]   w_timer_inc;
    logic [c_cw-1:0]   w_idx_inc;

    assign w_abort     = ganhou | perdeu;
    assign w_leds_nz   = (leds != 4'd0);
    assign w_onehot    = w_leds_nz && ((leds & (leds - 4'd1)) == 4'd0);
    assign w_timer_inc = r_timer + c_tw'(1);
    assign w_idx_inc   = r_idx + c_cw'(1);

    // State and datapath registers; reset aborts whatever is in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_INICIAL;
            r_n      <= '0;
            r_idx    <= '0;
            r_timer  <= '0;
            r_erro   <= 1'b0;
            r_botoes <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_n      <= w_n_next;
            r_idx    <= w_idx_next;
            r_timer  <= w_timer_next;
            r_erro   <= w_erro_next;
            r_botoes <= w_botoes_next;
        end
    end

    // Capture buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_buf[r_n[c_aw-1:0]] <= leds;
        end
    end

    // Next-state and datapath update; the timer is cleared on every exit.
    always_comb begin
        w_state_next  = r_state;
        w_n_next      = r_n;
        w_idx_next    = r_idx;
        w_timer_next  = r_timer;
        w_erro_next   = r_erro;
        w_botoes_next = r_botoes;
        w_wr          = 1'b0;

        case (r_state)
            S_INICIAL: begin
                w_botoes_next = 4'd0;
                if (iniciar) begin
                    w_state_next = S_DISPARA;
                    w_erro_next  = 1'b0;
                    w_timer_next = '0;
                end
            end

            S_DISPARA: begin
                w_timer_next = '0;
                if (w_abort) begin
                    w_state_next  = S_FIM;
                    w_botoes_next = 4'd0;
                end else begin
                    w_state_next = S_ESPERA_LED;
                    w_n_next     = '0;
                    w_idx_next   = '0;
                end
            end

            S_ESPERA_LED: begin
                if (w_abort) begin
                    w_state_next  = S_FIM;
                    w_botoes_next = 4'd0;
                    w_timer_next  = '0;
                end else if (w_leds_nz) begin
                    w_timer_next = '0;
                    // A malformed pattern or a full buffer both end the run.
                    if (!w_onehot || (r_n == c_prof)) begin
                        w_state_next = S_FIM;
                        w_erro_next  = 1'b1;
                    end else begin
                        w_wr         = 1'b1;
                        w_n_next     = r_n + c_cw'(1);
                        w_state_next = S_LED_ALTO;
                    end
                end else if (r_n != '0) begin
                    if (w_timer_inc == c_silencio) begin
                        // Preview finished: start replay with the first entry
                        // already on botoes in the next cycle.
                        w_state_next  = S_PRESSIONA;
                        w_idx_next    = '0;
                        w_timer_next  = '0;
                        w_botoes_next = r_buf[0];
                    end else begin
                        w_timer_next = w_timer_inc;
                    end
                end else begin
                    w_timer_next = '0;
                end
            end

            S_LED_ALTO: begin
                w_timer_next = '0;
                if (w_abort) begin
                    w_state_next  = S_FIM;
                    w_botoes_next = 4'd0;
                end else if (!w_leds_nz) begin
                    w_state_next = S_ESPERA_LED;
                end
            end

            S_PRESSIONA: begin
                if (w_abort) begin
                    w_state_next  = S_FIM;
                    w_botoes_next = 4'd0;
                    w_timer_next  = '0;
                end else if (w_timer_inc == c_press) begin
                    w_state_next  = S_INTERVALO;
                    w_botoes_next = 4'd0;
                    w_timer_next  = '0;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end

            S_INTERVALO: begin
                if (w_abort) begin
                    w_state_next  = S_FIM;
                    w_botoes_next = 4'd0;
                    w_timer_next  = '0;
                end else if (w_timer_inc == c_gap) begin
                    w_timer_next = '0;
                    if (w_idx_inc == r_n) begin
                        // Whole sequence replayed: wait for the longer preview.
                        w_state_next = S_ESPERA_LED;
                        w_n_next     = '0;
                        w_idx_next   = '0;
                    end else begin
                        w_state_next  = S_PRESSIONA;
                        w_idx_next    = w_idx_inc;
                        w_botoes_next = r_buf[w_idx_inc[c_aw-1:0]];
                    end
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end

            S_FIM: begin
                w_botoes_next = 4'd0;
                w_timer_next  = '0;
                if (iniciar) begin
                    w_state_next = S_DISPARA;
                    w_erro_next  = 1'b0;
                end
            end

            default: begin
                w_state_next  = S_INICIAL;
                w_botoes_next = 4'd0;
                w_timer_next  = '0;
            end
        endcase
    end

    assign botoes      = r_botoes;
    assign jogar       = (r_state == S_DISPARA);
    assign fim         = (r_state == S_FIM);
    assign erro        = r_erro;
    assign db_estado   = r_state;
    assign db_contagem = r_n;
    assign db_indice   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_playseq_jogador_automatico.sv
`default_nettype none
// ============================================================================
// Module      : tb_playseq_jogador_automatico
// Description : Directed self-checking bench for the automatic PlaySeq player.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_playseq_jogador_automatico;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic [3:0] botoes;
    logic       jogar;
    logic       fim;
    logic       erro;
    logic [3:0] db_estado;
    logic [4:0] db_contagem;
    logic [4:0] db_indice;

    int n_checks = 0;
    int n_fail   = 0;

    playseq_jogador_automatico #(
        .PROFUNDIDADE   (16),
        .PRESS_CICLOS   (5),
        .GAP_CICLOS     (5),
        .SILENCIO_CICLOS(20)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .leds       (leds),
        .ganhou     (ganhou),
        .perdeu     (perdeu),
        .botoes     (botoes),
        .jogar      (jogar),
        .fim        (fim),
        .erro       (erro),
        .db_estado  (db_estado),
        .db_contagem(db_contagem),
        .db_indice  (db_indice)
    );

    always #5 clock = ~clock;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Show one LED for 'hi' cycles, then dark for 'lo' cycles.
    task automatic flash(input logic [3:0] v, input int hi, input int lo);
        leds = v;
        repeat (hi) tick();
        leds = 4'd0;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        iniciar = 1'b0; leds = 4'd0; ganhou = 1'b0; perdeu = 1'b0;
        repeat (2) tick();
        n_checks++; if (botoes !== 4'd0) begin n_fail++; $display("FAIL reset_botoes: got %b expected 0000", botoes); end
        n_checks++; if (jogar !== 1'b0 || fim !== 1'b0 || erro !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got jogar=%b fim=%b erro=%b expected 0 0 0", jogar, fim, erro); end
        n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
        n_checks++; if (db_contagem !== 5'd0 || db_indice !== 5'd0) begin n_fail++; $display("FAIL reset_counts: got n=%0d idx=%0d expected 0 0", db_contagem, db_indice); end
        reset = 1'b0;
        tick();
        n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL idle_estado: got %0d expected 0", db_estado); end
    endtask

    task automatic test_start();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_checks++; if (db_estado !== 4'd1) begin n_fail++; $display("FAIL start_estado1: got %0d expected 1", db_estado); end
        n_checks++; if (jogar !== 1'b1) begin n_fail++; $display("FAIL start_jogar_hi: got %b expected 1", jogar); end
        tick();
        n_checks++; if (db_estado !== 4'd2) begin n_fail++; $display("FAIL start_estado2: got %0d expected 2", db_estado); end
        n_checks++; if (jogar !== 1'b0) begin n_fail++; $display("FAIL start_jogar_lo: got %b expected 0", jogar); end
    endtask

    // One dark cycle leaves LED_ALTO, then 20 dark cycles in ESPERA_LED end the preview.
    task automatic test_capture_replay();
        logic [3:0] exp_b;
        logic [4:0] exp_i;
        flash(4'b0001, 3, 3);
        flash(4'b0100, 3, 20);
        n_checks++; if (db_contagem !== 5'd2) begin n_fail++; $display("FAIL cap_contagem: got %0d expected 2", db_contagem); end
        n_checks++; if (botoes !== 4'd0 || db_estado !== 4'd2) begin n_fail++; $display("FAIL cap_silence: got botoes=%b estado=%0d expected 0000 2", botoes, db_estado); end
        tick();
        for (int i = 0; i < 20; i++) begin
            exp_b = (i < 5) ? 4'b0001 : (i < 10) ? 4'b0000 : (i < 15) ? 4'b0100 : 4'b0000;
            exp_i = (i < 10) ? 5'd0 : 5'd1;
            n_checks++; if (botoes !== exp_b) begin n_fail++; $display("FAIL replay_botoes[%0d]: got %b expected %b", i, botoes, exp_b); end
            n_checks++; if (db_indice !== exp_i) begin n_fail++; $display("FAIL replay_indice[%0d]: got %0d expected %0d", i, db_indice, exp_i); end
            tick();
        end
        n_checks++; if (db_estado !== 4'd2 || db_contagem !== 5'd0) begin n_fail++; $display("FAIL replay_end: got estado=%0d n=%0d expected 2 0", db_estado, db_contagem); end
    endtask

    task automatic test_echo();
        logic [3:0] exp_b;
        flash(4'b0010, 3, 3);
        flash(4'b0001, 3, 21);
        for (int i = 0; i < 20; i++) begin
            exp_b = (i < 5) ? 4'b0010 : (i < 10) ? 4'b0000 : (i < 15) ? 4'b0001 : 4'b0000;
            n_checks++; if (botoes !== exp_b) begin n_fail++; $display("FAIL echo_botoes[%0d]: got %b expected %b", i, botoes, exp_b); end
            n_checks++; if (db_contagem !== 5'd2) begin n_fail++; $display("FAIL echo_contagem[%0d]: got %0d expected 2", i, db_contagem); end
            leds = (i < 14) ? 4'b1000 : 4'b0000;
            tick();
        end
        leds = 4'd0;
        n_checks++; if (db_estado !== 4'd2 || db_contagem !== 5'd0) begin n_fail++; $display("FAIL echo_end: got estado=%0d n=%0d expected 2 0", db_estado, db_contagem); end
    endtask

    task automatic test_abort();
        flash(4'b0100, 3, 21);
        n_checks++; if (botoes !== 4'b0100 || db_estado !== 4'd4) begin n_fail++; $display("FAIL abort_press: got botoes=%b estado=%0d expected 0100 4", botoes, db_estado); end
        repeat (2) tick();
        perdeu = 1'b1;
        tick();
        perdeu = 1'b0;
        n_checks++; if (botoes !== 4'd0) begin n_fail++; $display("FAIL abort_botoes: got %b expected 0000", botoes); end
        n_checks++; if (fim !== 1'b1 || db_estado !== 4'd6) begin n_fail++; $display("FAIL abort_fim: got fim=%b estado=%0d expected 1 6", fim, db_estado); end
        tick();
        n_checks++; if (db_estado !== 4'd6) begin n_fail++; $display("FAIL abort_hold: got %0d expected 6", db_estado); end
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_checks++; if (jogar !== 1'b1 || fim !== 1'b0 || db_estado !== 4'd1) begin n_fail++; $display("FAIL restart: got jogar=%b fim=%b estado=%0d expected 1 0 1", jogar, fim, db_estado); end
        tick();
        n_checks++; if (jogar !== 1'b0 || db_estado !== 4'd2) begin n_fail++; $display("FAIL restart_espera: got jogar=%b estado=%0d expected 0 2", jogar, db_estado); end
    endtask

    task automatic test_erro_not_onehot();
        leds = 4'b0011;
        tick();
        leds = 4'd0;
        n_checks++; if (erro !== 1'b1 || fim !== 1'b1 || db_estado !== 4'd6) begin n_fail++; $display("FAIL bad_leds: got erro=%b fim=%b estado=%0d expected 1 1 6", erro, fim, db_estado); end
        n_checks++; if (db_contagem !== 5'd0) begin n_fail++; $display("FAIL bad_leds_contagem: got %0d expected 0", db_contagem); end
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_checks++; if (erro !== 1'b0 || db_estado !== 4'd1) begin n_fail++; $display("FAIL erro_clear: got erro=%b estado=%0d expected 0 1", erro, db_estado); end
        tick();
    endtask

    task automatic test_overflow();
        logic [3:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 4'b0001 << (i % 4);
            flash(v, 2, 2);
        end
        n_checks++; if (db_contagem !== 5'd16 || erro !== 1'b0 || db_estado !== 4'd2) begin n_fail++; $display("FAIL full_buffer: got n=%0d erro=%b estado=%0d expected 16 0 2", db_contagem, erro, db_estado); end
        leds = 4'b0001;
        tick();
        leds = 4'd0;
        n_checks++; if (erro !== 1'b1 || db_estado !== 4'd6) begin n_fail++; $display("FAIL overflow: got erro=%b estado=%0d expected 1 6", erro, db_estado); end
        n_checks++; if (db_contagem !== 5'd16) begin n_fail++; $display("FAIL overflow_contagem: got %0d expected 16", db_contagem); end
    endtask

    task automatic test_async_reset();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        flash(4'b0001, 3, 21);
        repeat (5) tick();
        n_checks++; if (db_estado !== 4'd5 || botoes !== 4'd0 || db_contagem !== 5'd1) begin n_fail++; $display("FAIL pre_reset: got estado=%0d botoes=%b n=%0d expected 5 0000 1", db_estado, botoes, db_contagem); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL async_estado: got %0d expected 0", db_estado); end
        n_checks++; if (botoes !== 4'd0 || jogar !== 1'b0 || fim !== 1'b0 || erro !== 1'b0) begin n_fail++; $display("FAIL async_outputs: got botoes=%b jogar=%b fim=%b erro=%b expected all 0", botoes, jogar, fim, erro); end
        n_checks++; if (db_contagem !== 5'd0 || db_indice !== 5'd0) begin n_fail++; $display("FAIL async_counts: got n=%0d idx=%0d expected 0 0", db_contagem, db_indice); end
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL post_reset: got %0d expected 0", db_estado); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_capture_replay();
        test_echo();
        test_abort();
        test_erro_not_onehot();
        test_overflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/playseq_jogador_automatico.md
Name: playseq_jogador_automatico

Overview:
- Automatic player for the PlaySeq game: sits on the opposite end of the game's leds/botoes interface and replaces the human.
- Watches the LED preview, captures the shown sequence into an internal buffer, then replays it as timed one-hot button presses.
- Stops when the game reports ganhou or perdeu.
- Used for bench regression of the game and for FPGA self-play demos; its botoes output drives the game's botoes input directly.

Parameters:
- PROFUNDIDADE, 16: maximum number of captured entries; must be a power of 2.
- PRESS_CICLOS, 5: cycles each button press is held.
- GAP_CICLOS, 5: cycles with botoes = 0 after each press.
- SILENCIO_CICLOS, 20: cycles of leds == 0 (after at least one capture) that mark the end of the preview.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- iniciar  input  1  one-cycle start request
- leds  input  4  game LED outputs (one-hot while lit)
- ganhou  input  1  game win flag
- perdeu  input  1  game loss flag
- botoes  output  4  one-hot button presses to the game
- jogar  output  1  one-cycle start pulse to the game
- fim  output  1  high while in FIM
- erro  output  1  sticky error flag, cleared by iniciar or reset
- db_estado  output  4  current state code
- db_contagem  output  log2(PROFUNDIDADE)+1  number of captured entries (n)
- db_indice  output  log2(PROFUNDIDADE)+1  current replay index

Behaviour:
- Reset (async, active-high): state INICIAL; botoes = 0, jogar = 0, fim = 0, erro = 0, n = 0, idx = 0, all timers 0. Reset mid-operation aborts immediately; the buffer contents need not be cleared.
- States and db_estado codes:
  - 0 INICIAL: idle, all outputs 0. iniciar -> DISPARA; erro cleared.
  - 1 DISPARA: jogar = 1 for exactly this one cycle; n = 0 -> ESPERA_LED.
  - 2 ESPERA_LED: leds == 0 is expected here.
    - If leds is nonzero and one-hot: buf[n] <= leds, n <= n+1 -> LED_ALTO; silence timer cleared.
    - If leds is nonzero and not one-hot: erro = 1 -> FIM.
    - If leds is one-hot and n == PROFUNDIDADE (overflow): erro = 1 -> FIM, nothing stored.
    - If leds == 0 and n > 0: the silence timer increments. On reaching SILENCIO_CICLOS -> PRESSIONA with idx = 0. While n == 0 the timer stays 0.
  - 3 LED_ALTO: waits for leds == 0 -> ESPERA_LED. A change to a different nonzero value while lit is ignored; only 0 -> nonzero edges capture.
  - 4 PRESSIONA: botoes = buf[idx] for exactly PRESS_CICLOS cycles -> INTERVALO. leds is ignored, since the game may echo presses on its LEDs.
  - 5 INTERVALO: botoes = 0 for exactly GAP_CICLOS cycles, leds ignored. Then idx <= idx+1. If idx+1 == n: n <= 0, idx <= 0 -> ESPERA_LED to capture the next, longer preview. Otherwise -> PRESSIONA.
  - 6 FIM: fim = 1, botoes = 0. iniciar -> DISPARA (erro cleared). Holds otherwise.
- ganhou or perdeu seen in any state 1-5 -> FIM on the next edge. botoes drops to 0 in the same transition, even mid-press.
- Precedence: ganhou/perdeu over every other transition in the same cycle; iniciar is ignored in states 1-5.
- botoes is registered: never X, never more than one bit set.
- Latency:
  - ESPERA_LED silence expiry to first botoes assertion: 1 cycle.
  - Capture: a leds rising value is stored on the first clock edge it is seen.
- Timer widths: sized for the largest parameter; no wrap occurs since each timer is cleared on every state exit.

Test Plan:
- Start: iniciar pulse -> jogar high for exactly 1 cycle, db_estado 0 -> 1 -> 2.
- Capture/replay: drive leds 0001 (3 cyc), 0 (3), 0100 (3), 0 (20) -> db_contagem = 2. Then botoes = 0001 for 5 cycles, 0000 for 5, 0100 for 5, 0000 for 5; then db_estado = 2 and db_contagem = 0.
- Echo immunity: during replay, drive leds = 1000 -> no capture, db_contagem unchanged, replay sequence identical.
- Abort: assert perdeu mid-press (3rd cycle of PRESSIONA) -> next cycle botoes = 0, fim = 1, db_estado = 6. Then iniciar -> jogar pulse, fim = 0.
- Errors:
  - leds = 0011 in ESPERA_LED -> erro = 1, FIM.
  - 17 distinct flashes with PROFUNDIDADE = 16 -> erro = 1 on the 17th, db_contagem = 16.
- Async reset during INTERVALO -> all outputs 0 immediately (before the next clock edge), db_estado = 0.
